// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: break-before-make sequencer for a two-source glitch-free
// clock mux. It turns a select level into an ordered sequence: disable the
// old source, wait for its resynchronised feedback to report "off", then
// enable the new source and wait for "running". Each wait is bounded by a
// timeout that forces progress and raises a sticky error flag.
//
// Ports:
//   clk      control clock, all state updates on rising edge
//   rst      synchronous active-high reset
//   sel      requested source (0/1), synchronous to clk
//   fb0/fb1  asynchronous "source running" feedback from each flop chain
//   err_clr  one-cycle pulse clearing err
//   en0/en1  registered enables toward each source's flop chain
//   cur_sel  source currently committed
//   busy     high while a switch is in progress
//   done     one-cycle pulse when a switch completes
//   err      sticky timeout flag
module clk_sel_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic fb0,
  input  logic fb1,
  input  logic err_clr,
  output logic en0,
  output logic en1,
  output logic cur_sel,
  output logic busy,
  output logic done,
  output logic err
);

  // Timeout fires on the cycle the counter would step onto TIMEOUT_CYCLES,
  // so a wait state lasts at most TIMEOUT_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STOP  = 2'd1,
    START = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] fb0_sync_q, fb0_sync_d;
  logic [SYNC_STAGES-1:0] fb1_sync_q, fb1_sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tgt_q, tgt_d;
  logic                   cur_sel_q, cur_sel_d;
  logic                   en0_q, en0_d;
  logic                   en1_q, en1_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic fb0_s, fb1_s;
  logic fb_old_c, fb_new_c, timeout_c;

  // Feedback resynchronisers: shift in at bit 0, consume the top bit.
  always_comb begin
    fb0_sync_d = {fb0_sync_q[SYNC_STAGES-2:0], fb0};
    fb1_sync_d = {fb1_sync_q[SYNC_STAGES-2:0], fb1};
  end

  assign fb0_s = fb0_sync_q[SYNC_STAGES-1];
  assign fb1_s = fb1_sync_q[SYNC_STAGES-1];

  assign fb_old_c  = cur_sel_q ? fb1_s : fb0_s;
  assign fb_new_c  = tgt_q ? fb1_s : fb0_s;
  assign timeout_c = (state_q != RUN) && (cnt_q >= CNT_LAST);

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cur_sel_d = cur_sel_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      RUN: begin
        if (sel != cur_sel_q) begin
          tgt_d   = sel;
          state_d = STOP;
        end
      end
      STOP: begin
        if (!fb_old_c || timeout_c) begin
          state_d = START;
        end
      end
      START: begin
        if (fb_new_c || timeout_c) begin
          state_d   = RUN;
          cur_sel_d = tgt_q;
          done_d    = 1'b1;
        end
      end
      default: state_d = START;
    endcase

    // Counter restarts on every state entry and only advances while waiting.
    if (state_d != state_q || state_q == RUN) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Set has priority over clear.
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (timeout_c) begin
      err_d = 1'b1;
    end

    // Enables come from the next state so they switch with the state edge;
    // each branch drives at most one enable high.
    en0_d  = ((state_d == RUN) && !cur_sel_d) || ((state_d == START) && !tgt_d);
    en1_d  = ((state_d == RUN) &&  cur_sel_d) || ((state_d == START) &&  tgt_d);
    busy_d = (state_d != RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START;
      fb0_sync_q <= '0;
      fb1_sync_q <= '0;
      cnt_q      <= '0;
      tgt_q      <= 1'b0;
      cur_sel_q  <= 1'b0;
      en0_q      <= 1'b0;
      en1_q      <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fb0_sync_q <= fb0_sync_d;
      fb1_sync_q <= fb1_sync_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      cur_sel_q  <= cur_sel_d;
      en0_q      <= en0_d;
      en1_q      <= en1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign en0     = en0_q;
  assign en1     = en1_q;
  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Testbench for clk_sel_ctrl: behavioural source models answer each enable
// with a configurable cycle delay (or are held stuck high), the stimulus
// process queues expected done responses and point checks, and a monitor on
// the falling edge performs every comparison.
module tb_clk_sel_ctrl;

  localparam int NS = 99;

  logic clk = 1'b0;
  logic rst, sel, err_clr;
  logic fb0 = 1'b0;
  logic fb1 = 1'b0;
  logic en0, en1, cur_sel, busy, done, err;

  always #5 clk = ~clk;

  clk_sel_ctrl #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .fb0    (fb0),
    .fb1    (fb1),
    .err_clr(err_clr),
    .en0    (en0),
    .en1    (en1),
    .cur_sel(cur_sel),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Source models: feedback follows the enable dly cycles later, or is stuck high.
  logic [7:0] hist0 = '0;
  logic [7:0] hist1 = '0;
  int         dly0  = 2;
  int         dly1  = 3;
  bit         frc0  = 1'b0;
  bit         frc1  = 1'b0;

  always @(posedge clk) begin
    #2;
    hist0 = {hist0[6:0], en0};
    hist1 = {hist1[6:0], en1};
    fb0   = frc0 ? 1'b1 : hist0[dly0];
    fb1   = frc1 ? 1'b1 : hist1[dly1];
  end

  typedef struct packed {
    logic cur;
    logic err;
  } exp_t;

  exp_t        exp_q[$];
  string       nm_q[$];
  logic [63:0] val_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nm_q.push_back(nm);
    val_q.push_back({act, exp});
  endtask

  // Monitor: drains point checks, enforces enable exclusivity, scores done pulses.
  always @(negedge clk) begin
    logic [63:0] v;
    string       nm;
    exp_t        e;
    while (nm_q.size() > 0) begin
      nm = nm_q.pop_front();
      v  = val_q.pop_front();
      n_tests++;
      if (v[63:32] !== v[31:0]) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", nm, v[63:32], v[31:0]);
      end
    end
    if (mon_en) begin
      n_tests++;
      if (en0 === 1'b1 && en1 === 1'b1) begin
        n_fail++;
        $display("FAIL en_overlap: got en0=%b en1=%b, expected not both 1", en0, en1);
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: got done=1, expected no pulse");
        end else begin
          e = exp_q.pop_front();
          n_tests += 2;
          if (cur_sel !== e.cur) begin
            n_fail++;
            $display("FAIL done_cur_sel: got %b, expected %b", cur_sel, e.cur);
          end
          if (err !== e.err) begin
            n_fail++;
            $display("FAIL done_err: got %b, expected %b", err, e.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until done (bounded), recording the first cycle of each event.
  task automatic run_switch(input int max, output int t0off, output int t0on,
                            output int t1on, output int terr, output int tdone);
    t0off = NS; t0on = NS; t1on = NS; terr = NS; tdone = NS;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (en0 === 1'b0 && t0off == NS) t0off = i;
      if (en0 === 1'b1 && t0on == NS)  t0on  = i;
      if (en1 === 1'b1 && t1on == NS)  t1on  = i;
      if (err === 1'b1 && terr == NS)  terr  = i;
      if (done === 1'b1) begin
        tdone = i;
        break;
      end
    end
  endtask

  initial begin
    int a, b, c, d, t;
    int seen;
    rst = 1'b1; sel = 1'b0; err_clr = 1'b0;

    // Reset: hold 3 cycles.
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    chk("rst_en0", en0, 0);
    chk("rst_en1", en1, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_sel", cur_sel, 0);

    // Initial commit of source 0, fb0 answers 2 cycles after en0.
    exp_q.push_back('{cur: 1'b0, err: 1'b0});
    rst = 1'b0;
    run_switch(30, a, b, c, d, t);
    chk("start_en0_cycle", b, 1);
    chk("start_done_cycle", t, 6);
    chk("start_busy", busy, 0);
    chk("start_en0", en0, 1);
    chk("start_en1", en1, 0);

    // Normal switch 0 -> 1, feedback delay 3.
    dly0 = 3;
    tick();
    sel = 1'b1;
    exp_q.push_back('{cur: 1'b1, err: 1'b0});
    run_switch(40, a, b, c, d, t);
    chk("sw01_en0_off_cycle", a, 1);
    chk("sw01_en1_on_cycle", c, 7);
    chk("sw01_done_cycle", t, 13);
    chk("sw01_busy", busy, 0);
    chk("sw01_en1", en1, 1);

    // Normal switch 1 -> 0.
    tick();
    sel = 1'b0;
    exp_q.push_back('{cur: 1'b0, err: 1'b0});
    run_switch(40, a, b, c, d, t);
    chk("sw10_en0_on_cycle", b, 7);
    chk("sw10_done_cycle", t, 13);

    // sel glitch while busy: switch to 1 completes, then a switch back to 0.
    tick();
    sel = 1'b1;
    exp_q.push_back('{cur: 1'b1, err: 1'b0});
    exp_q.push_back('{cur: 1'b0, err: 1'b0});
    tick();
    chk("glitch_busy", busy, 1);
    sel = 1'b0;
    run_switch(40, a, b, c, d, t);
    chk("glitch_first_done", t, 12);
    tick();
    chk("glitch_restart_busy", busy, 1);
    chk("glitch_restart_en1", en1, 0);
    chk("glitch_restart_en0", en0, 0);
    run_switch(40, a, b, c, d, t);
    chk("glitch_second_done", t, 12);
    chk("glitch_final_en0", en0, 1);

    // Dead old clock: fb0 stuck high, switch 0 -> 1 must time out.
    tick();
    frc0 = 1'b1;
    sel  = 1'b1;
    exp_q.push_back('{cur: 1'b1, err: 1'b1});
    run_switch(40, a, b, c, d, t);
    chk("dead_en1_on_cycle", c, 9);
    chk("dead_err_cycle", d, 9);
    chk("dead_done_cycle", t, 15);
    frc0 = 1'b0;
    tick();
    tick();
    tick();
    chk("dead_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("dead_err_cleared", err, 0);

    // Timeout and err_clr in the same cycle: set wins.
    frc1 = 1'b1;
    sel  = 1'b0;
    exp_q.push_back('{cur: 1'b0, err: 1'b1});
    for (int i = 1; i <= 8; i++) tick();
    chk("simul_err_before", err, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("simul_err_set", err, 1);
    chk("simul_en0_start", en0, 1);
    run_switch(30, a, b, c, d, t);
    chk("simul_done_cycle", t, 6);
    frc1 = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("simul_err_cleared", err, 0);

    // Reset mid-switch while START drives en1.
    tick();
    sel  = 1'b1;
    seen = NS;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (en1 === 1'b1) begin
        seen = i;
        break;
      end
    end
    chk("midrst_en1_on_cycle", seen, 7);
    rst = 1'b1;
    tick();
    chk("midrst_en0", en0, 0);
    chk("midrst_en1", en1, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_cur_sel", cur_sel, 0);
    sel = 1'b0;
    tick();
    exp_q.push_back('{cur: 1'b0, err: 1'b0});
    rst = 1'b0;
    run_switch(30, a, b, c, d, t);
    chk("midrst_en0_on_cycle", b, 1);
    chk("midrst_en1_never", c, NS);
    chk("midrst_done_cycle", t, 7);

    tick();
    tick();
    chk("exp_q_empty", exp_q.size(), 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
